// File: rtl/vram_arbiter_if.sv
// Client-side request/grant bus and VRAM pin bundle shared by vram_arbiter and its users.
// slave = arbiter view, master = clients plus VRAM device view.
interface vram_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16
);
    localparam int BE = DATA_WIDTH / 8;

    logic [NUM_CLIENTS-1:0]            req;
    logic [NUM_CLIENTS-1:0]            wr;
    logic [NUM_CLIENTS*BE-1:0]         be;
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr;
    logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata;
    logic [NUM_CLIENTS-1:0]            grant;
    logic [NUM_CLIENTS-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]             rdata;

    logic                              vram_en;
    logic                              vram_rd;
    logic                              vram_wr;
    logic [BE-1:0]                     vram_be;
    logic [ADDR_WIDTH-1:0]             vram_addr;
    logic [DATA_WIDTH-1:0]             vram_data_out;
    logic [DATA_WIDTH-1:0]             vram_data_in;

    modport slave (
        input  req, wr, be, addr, wdata, vram_data_in,
        output grant, rvalid, rdata,
               vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out
    );

    modport master (
        output req, wr, be, addr, wdata, vram_data_in,
        input  grant, rvalid, rdata,
               vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out
    );
endinterface

// File: rtl/vram_arbiter.sv
// Round-robin VRAM port arbiter with bounded bursts; ARB_CLIENT0_PRIORITY_EN gives client 0 strict priority.
// Pins registered 1 cycle after accept, rvalid READ_LATENCY after the read hits the pins; clients hold req until granted.
module vram_arbiter #(
    parameter int NUM_CLIENTS  = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 8
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    localparam int BE   = DATA_WIDTH / 8;
    localparam int IDXW = $clog2(NUM_CLIENTS);
    localparam int BW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic            vld;
        logic [IDXW-1:0] idx;
    } rd_tag_t;

    state_t                       state_q, state_d;
    logic [NUM_CLIENTS-1:0]       grant_q, grant_d;
    logic [IDXW-1:0]              ptr_q, ptr_d;
    logic [BW-1:0]                beats_q, beats_d;
    logic                         en_q, en_d;
    logic                         rd_q, rd_d;
    logic                         wr_q, wr_d;
    logic [BE-1:0]                be_q, be_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        dout_q, dout_d;
    rd_tag_t [READ_LATENCY-1:0]   pipe_q, pipe_d;
    logic [NUM_CLIENTS-1:0]       rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;

    logic                         accept;
    logic                         arb_point;
    logic                         win_vld;
    logic [IDXW-1:0]              win_idx;

    // Winner search starts just after the last winner, so the current holder is considered last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            if (!win_vld && bus.req[IDXW'((int'(ptr_q) + i) % NUM_CLIENTS)]) begin
                win_vld = 1'b1;
                win_idx = IDXW'((int'(ptr_q) + i) % NUM_CLIENTS);
            end
        end
`ifdef ARB_CLIENT0_PRIORITY_EN
        if (bus.req[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        beats_d   = beats_q;
        accept    = |(bus.req & grant_q);
        arb_point = 1'b0;

        if (state_q == GRANT) begin
            arb_point = !bus.req[ptr_q] || (beats_q == BW'(MAX_BURST - 1));
`ifdef ARB_CLIENT0_PRIORITY_EN
            if (bus.req[0] && (ptr_q != '0)) begin
                arb_point = 1'b1;
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    grant_d = NUM_CLIENTS'(1) << win_idx;
                    ptr_d   = win_idx;
                    beats_d = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    beats_d = beats_q + BW'(1);
                end
                if (arb_point) begin
                    beats_d = '0;
                    if (win_vld) begin
                        grant_d = NUM_CLIENTS'(1) << win_idx;
                        ptr_d   = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        en_d   = accept;
        rd_d   = accept & ~bus.wr[ptr_q];
        wr_d   = accept &  bus.wr[ptr_q];
        be_d   = be_q;
        addr_d = addr_q;
        dout_d = dout_q;
        if (accept) begin
            be_d   = bus.be[int'(ptr_q)*BE +: BE];
            addr_d = bus.addr[int'(ptr_q)*ADDR_WIDTH +: ADDR_WIDTH];
            dout_d = bus.wdata[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
        end

        // Stage 0 is valid in the same cycle the read is on the pins.
        pipe_d[0].vld = accept & ~bus.wr[ptr_q];
        pipe_d[0].idx = ptr_q;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end

        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (pipe_q[READ_LATENCY-1].vld) begin
            rvalid_d[pipe_q[READ_LATENCY-1].idx] = 1'b1;
            rdata_d = bus.vram_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= IDXW'(NUM_CLIENTS - 1);
            beats_q  <= '0;
            en_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            pipe_q   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            beats_q  <= beats_d;
            en_q     <= en_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            pipe_q   <= pipe_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.rvalid        = rvalid_q;
    assign bus.rdata         = rdata_q;
    assign bus.vram_en       = en_q;
    assign bus.vram_rd       = rd_q;
    assign bus.vram_wr       = wr_q;
    assign bus.vram_be       = be_q;
    assign bus.vram_addr     = addr_q;
    assign bus.vram_data_out = dout_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: 4 clients, 16-bit address/data, READ_LATENCY 2, MAX_BURST 8.
module tb_vram_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    logic mem_fixed;

    vram_arbiter_if #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    vram_arbiter #(
        .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .READ_LATENCY(2), .MAX_BURST(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] caddr(input int i);
        return 16'h1000 * 16'(i + 1) + 16'h0040;
    endfunction

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.vram_data_in = mem_fixed ? 16'hBEEF : 16'hA000 + 16'(cyc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.wr  = '0;
        bus.be  = '1;
        for (int i = 0; i < N; i++) begin
            bus.addr[i*AW +: AW]  = caddr(i);
            bus.wdata[i*DW +: DW] = 16'h7000 + 16'(i);
        end
        step();
        step();
        reset = 1'b0;
        cyc = 0;
        bus.vram_data_in = mem_fixed ? 16'hBEEF : 16'hA000;
    endtask

    task automatic test_reset();
        logic [95:0] obs;
        mem_fixed = 1'b0;
        do_reset();
        obs = {bus.grant, bus.rvalid, bus.rdata, bus.vram_en, bus.vram_rd, bus.vram_wr,
               bus.vram_be, bus.vram_addr, bus.vram_data_out};
        checks++;
        if (obs !== 96'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", obs);
        end
    endtask

    task automatic test_single_read();
        mem_fixed = 1'b1;
        do_reset();
        bus.req = 4'b0001;
        bus.addr[0 +: AW] = 16'h0123;
        step();
        checks++;
        if (bus.grant !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant c1 got=%b exp=0001", bus.grant);
        end
        step();
        checks++;
        if ({bus.vram_en, bus.vram_rd, bus.vram_wr, bus.vram_addr} !== {3'b110, 16'h0123}) begin
            failures++;
            $display("FAIL single_pins c2 got en=%b rd=%b wr=%b addr=%h exp en=1 rd=1 wr=0 addr=0123",
                     bus.vram_en, bus.vram_rd, bus.vram_wr, bus.vram_addr);
        end
        step();
        checks++;
        if (bus.rvalid !== 4'b0000) begin
            failures++;
            $display("FAIL single_rvalid_early c3 got=%b exp=0000", bus.rvalid);
        end
        step();
        checks++;
        if (bus.rvalid !== 4'b0001 || bus.rdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL single_rdata c4 got rvalid=%b rdata=%h exp rvalid=0001 rdata=beef",
                     bus.rvalid, bus.rdata);
        end
        bus.req = '0;
        mem_fixed = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        do_reset();
        bus.req = 4'b1111;
        bus.wr  = 4'b0000;
        for (int c = 1; c <= 36; c++) begin
            step();
            eg = 4'b0001 << ((c - 1) / 8 % 4);
            checks++;
            if (bus.grant !== eg) begin
                failures++;
                $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.grant, eg);
            end
            if (c >= 2) begin
                checks++;
                if (bus.vram_en !== 1'b1 || bus.vram_rd !== 1'b1 ||
                    bus.vram_addr !== caddr((c - 2) / 8 % 4)) begin
                    failures++;
                    $display("FAIL rr_pins c=%0d got en=%b rd=%b addr=%h exp en=1 rd=1 addr=%h",
                             c, bus.vram_en, bus.vram_rd, bus.vram_addr, caddr((c - 2) / 8 % 4));
                end
            end
            if (c >= 4) begin
                checks++;
                if (bus.rvalid !== (4'b0001 << ((c - 4) / 8 % 4)) ||
                    bus.rdata !== 16'hA000 + 16'(c - 1)) begin
                    failures++;
                    $display("FAIL rr_rvalid c=%0d got rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                             c, bus.rvalid, bus.rdata, 4'b0001 << ((c - 4) / 8 % 4),
                             16'hA000 + 16'(c - 1));
                end
            end
        end
        bus.req = '0;
    endtask

    task automatic test_lone_writer();
        int n_en;
        n_en = 0;
        do_reset();
        bus.req = 4'b0100;
        bus.wr  = 4'b0100;
        bus.wdata[2*DW +: DW] = 16'h5000;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c >= 21) bus.req = 4'b0000;
            bus.wdata[2*DW +: DW] = 16'h5000 + 16'(c);
            if (bus.vram_en === 1'b1) n_en++;
            checks++;
            if (bus.grant !== ((c <= 21) ? 4'b0100 : 4'b0000)) begin
                failures++;
                $display("FAIL lone_grant c=%0d got=%b exp=%b", c, bus.grant,
                         (c <= 21) ? 4'b0100 : 4'b0000);
            end
            if (c >= 2 && c <= 21) begin
                checks++;
                if ({bus.vram_en, bus.vram_rd, bus.vram_wr} !== 3'b101 ||
                    bus.vram_data_out !== 16'h5000 + 16'(c - 1)) begin
                    failures++;
                    $display("FAIL lone_pins c=%0d got en=%b rd=%b wr=%b dout=%h exp en=1 rd=0 wr=1 dout=%h",
                             c, bus.vram_en, bus.vram_rd, bus.vram_wr, bus.vram_data_out,
                             16'h5000 + 16'(c - 1));
                end
            end
            checks++;
            if (bus.rvalid !== 4'b0000) begin
                failures++;
                $display("FAIL lone_rvalid c=%0d got=%b exp=0000", c, bus.rvalid);
            end
        end
        checks++;
        if (n_en != 20) begin
            failures++;
            $display("FAIL lone_count got=%0d exp=20", n_en);
        end
        bus.wr = '0;
    endtask

    task automatic test_drop();
        int n1;
        logic [3:0] eg;
        n1 = 0;
        do_reset();
        bus.req = 4'b1010;
        for (int c = 1; c <= 13; c++) begin
            step();
            bus.req = (c == 4 || c == 5) ? 4'b1000 : 4'b1010;
            eg = (c <= 4) ? 4'b0010 : (c <= 12) ? 4'b1000 : 4'b0010;
            if (bus.vram_en === 1'b1 && bus.vram_addr === caddr(1)) n1++;
            checks++;
            if (bus.grant !== eg) begin
                failures++;
                $display("FAIL drop_grant c=%0d got=%b exp=%b", c, bus.grant, eg);
            end
        end
        checks++;
        if (n1 != 3) begin
            failures++;
            $display("FAIL drop_count got=%0d exp=3", n1);
        end
        bus.req = '0;
    endtask

    task automatic test_reset_inflight();
        logic [95:0] obs;
        do_reset();
        bus.req = 4'b0001;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.req = 4'b1011;
        obs = {bus.grant, bus.rvalid, bus.rdata, bus.vram_en, bus.vram_rd, bus.vram_wr,
               bus.vram_be, bus.vram_addr, bus.vram_data_out};
        checks++;
        if (obs !== 96'h0) begin
            failures++;
            $display("FAIL inflight_zero got=%h exp=0", obs);
        end
        for (int c = 5; c <= 7; c++) begin
            step();
            checks++;
            if (bus.rvalid !== 4'b0000) begin
                failures++;
                $display("FAIL inflight_rvalid c=%0d got=%b exp=0000", c, bus.rvalid);
            end
            if (c == 5) begin
                checks++;
                if (bus.grant !== 4'b0001) begin
                    failures++;
                    $display("FAIL inflight_grant got=%b exp=0001", bus.grant);
                end
            end
        end
        bus.req = '0;
    endtask

    task automatic test_priority();
        int first0;
        int n2;
        int exp_first;
        int exp_n2;
`ifdef ARB_CLIENT0_PRIORITY_EN
        exp_first = 5;
        exp_n2    = 4;
`else
        exp_first = 9;
        exp_n2    = 8;
`endif
        first0 = -1;
        n2 = 0;
        do_reset();
        bus.req = 4'b0100;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c >= 4) bus.req = 4'b0101;
            if (first0 < 0 && bus.grant === 4'b0001) first0 = c;
            if (bus.vram_en === 1'b1 && bus.vram_addr === caddr(2) && (first0 < 0 || c <= first0)) n2++;
            checks++;
            if ($countones(bus.grant) > 1) begin
                failures++;
                $display("FAIL prio_onehot c=%0d got=%b exp=at most one bit", c, bus.grant);
            end
        end
        checks++;
        if (first0 != exp_first) begin
            failures++;
            $display("FAIL prio_grant0_cycle got=%0d exp=%0d", first0, exp_first);
        end
        checks++;
        if (n2 != exp_n2) begin
            failures++;
            $display("FAIL prio_client2_beats got=%0d exp=%0d", n2, exp_n2);
        end
        bus.req = '0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        mem_fixed = 1'b0;
        reset     = 1'b1;
        bus.req   = '0;
        bus.wr    = '0;
        bus.be    = '1;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.vram_data_in = '0;
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lone_writer();
        test_drop();
        test_reset_inflight();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
